// File: rtl/key_schedule_iter.sv
// Iterative AES key expansion for AES-128/192/256: one schedule word per cycle,
// round keys delivered as 128-bit words over a valid/ready stream.

module roundsbox (
  input  logic [7:0] b,
  output logic [7:0] c
);
  // Multiplicative inverse as b^254 in GF(2^8), followed by the AES affine map
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] a;
    p = 8'h00;
    a = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  assign x2   = gmul(b, b);
  assign x3   = gmul(x2, b);
  assign x6   = gmul(x3, x3);
  assign x12  = gmul(x6, x6);
  assign x15  = gmul(x12, x3);
  assign x30  = gmul(x15, x15);
  assign x60  = gmul(x30, x30);
  assign x120 = gmul(x60, x60);
  assign x240 = gmul(x120, x120);
  assign x252 = gmul(x240, x12);
  assign inv  = gmul(x252, x2);

  assign c = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module key_schedule_iter #(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_index,
  output logic [127:0] rk_data,
  output logic         done
);
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] LAST_W   = 6'(NW - 1);
  localparam logic [5:0] NK_W     = 6'(NK);
  localparam logic [2:0] LAST_MOD = 3'(NK - 1);
  localparam logic [3:0] LAST_RK  = 4'(NR);

  generate
    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
      $error("key_schedule_iter: NK must be 4, 6 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  state_t      state;
  logic [5:0]  cnt;
  logic [2:0]  modc;
  logic [7:0]  rcon;
  logic [31:0] win [NK];
  logic [95:0] acc;
  logic [31:0] last_w, sb_in, sb_out, t, nw;
  logic        group_end, stall, produce;
  logic        unused_key;

  assign unused_key = ^key_in;

  // Window is oldest-first: win[0] = w[i-NK], win[NK-1] = w[i-1]
  assign last_w = win[NK-1];
  assign sb_in  = (modc == 3'd0) ? {last_w[23:0], last_w[31:24]} : last_w;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    roundsbox u_sbox (.b(sb_in[8*g +: 8]), .c(sb_out[8*g +: 8]));
  end

  always_comb begin
    t = last_w;
    if (modc == 3'd0)                  t = sb_out ^ {rcon, 24'h0};
    else if (NK == 8 && modc == 3'd4)  t = sb_out;
    // The window is preloaded with the key, so the first NK words rotate straight through
    nw = (cnt < NK_W) ? win[0] : (win[0] ^ t);
  end

  assign group_end = (cnt[1:0] == 2'b11);
  assign stall     = group_end && rk_valid && !rk_ready;
  assign produce   = (state == S_RUN) && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      modc     <= '0;
      rcon     <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_index <= '0;
      rk_data  <= '0;
      done     <= 1'b0;
      for (int j = 0; j < NK; j++) win[j] <= '0;
    end else begin
      done <= 1'b0;
      if (rk_valid && rk_ready) rk_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
            cnt   <= '0;
            modc  <= '0;
            rcon  <= 8'h01;
            for (int j = 0; j < NK; j++) win[j] <= key_in[255 - 32*j -: 32];
          end
        end
        S_RUN: begin
          if (produce) begin
            for (int j = 0; j < NK - 1; j++) win[j] <= win[j+1];
            win[NK-1] <= nw;
            cnt  <= cnt + 6'd1;
            modc <= (modc == LAST_MOD) ? 3'd0 : modc + 3'd1;
            if (cnt >= NK_W && modc == 3'd0) rcon <= xtime(rcon);
            if (group_end) begin
              rk_data  <= {acc, nw};
              rk_index <= cnt[5:2];
              rk_valid <= 1'b1;
            end else begin
              acc <= {acc[63:0], nw};
            end
            if (cnt == LAST_W) begin
              state <= S_DRAIN;
              cnt   <= '0;
              modc  <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (rk_valid && rk_ready && rk_index == LAST_RK) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_schedule_iter.sv
// Directed-vector bench for key_schedule_iter with one instance per key length.

module tb_key_schedule_iter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         rdy = 1'b1;
  logic [255:0] key = '0;
  int           sel = 0;

  logic         st4, st6, st8;
  logic         busy4, v4, d4, busy6, v6, d6, busy8, v8, d8;
  logic [3:0]   i4, i6, i8;
  logic [127:0] q4, q6, q8;

  assign st4 = start && (sel == 0);
  assign st6 = start && (sel == 1);
  assign st8 = start && (sel == 2);

  key_schedule_iter #(.NK(4)) u4 (.clk(clk), .rst(rst), .start(st4), .key_in(key), .busy(busy4),
    .rk_valid(v4), .rk_ready(rdy), .rk_index(i4), .rk_data(q4), .done(d4));
  key_schedule_iter #(.NK(6)) u6 (.clk(clk), .rst(rst), .start(st6), .key_in(key), .busy(busy6),
    .rk_valid(v6), .rk_ready(rdy), .rk_index(i6), .rk_data(q6), .done(d6));
  key_schedule_iter #(.NK(8)) u8 (.clk(clk), .rst(rst), .start(st8), .key_in(key), .busy(busy8),
    .rk_valid(v8), .rk_ready(rdy), .rk_index(i8), .rk_data(q8), .done(d8));

  logic         obs_busy, obs_valid, obs_done;
  logic [3:0]   obs_idx;
  logic [127:0] obs_data;

  always_comb begin
    obs_busy = busy4; obs_valid = v4; obs_done = d4; obs_idx = i4; obs_data = q4;
    if (sel == 1) begin
      obs_busy = busy6; obs_valid = v6; obs_done = d6; obs_idx = i6; obs_data = q6;
    end else if (sel == 2) begin
      obs_busy = busy8; obs_valid = v8; obs_done = d8; obs_idx = i8; obs_data = q8;
    end
  end

  always #5 clk = ~clk;

  localparam logic [255:0] K4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] EXP4 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

  int total = 0;
  int bad = 0;
  logic [127:0] kd [16];
  logic [3:0]   ki [16];
  int nacc, ndone, done_at, last_at, stable_bad;

  // Drives handshakes at the falling edge and records every accepted key
  task automatic collect(input bit do_start, input int restart_at, input bit b2b,
                         input bit rand_rdy, input int budget);
    logic         pend = 1'b0;
    logic [127:0] pd = '0;
    logic [3:0]   pi = '0;
    int           stall_n = 0;
    nacc = 0; ndone = 0; done_at = -10; last_at = -10; stable_bad = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (obs_done) begin ndone++; done_at = c; end
      if (pend && (!obs_valid || obs_data !== pd || obs_idx !== pi)) stable_bad++;
      if (rand_rdy && obs_valid && obs_idx == 4'd5 && stall_n < 20) begin
        rdy = 1'b0; stall_n++;
      end else if (rand_rdy) rdy = ($urandom_range(0, 9) >= 3);
      else rdy = 1'b1;
      start = 1'b0;
      if (do_start && c == 0) start = 1'b1;
      if (c == restart_at) begin start = 1'b1; key = ~K4; end
      if (b2b && obs_done) begin start = 1'b1; key = K4; end
      if (obs_valid && rdy) begin
        if (nacc < 16) begin kd[nacc] = obs_data; ki[nacc] = obs_idx; end
        nacc++; last_at = c;
      end
      pend = obs_valid && !rdy; pd = obs_data; pi = obs_idx;
      if (ndone > 0 && c >= done_at + 2) break;
    end
    start = 1'b0; rdy = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy4); end
    total++; if (v4 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", v4); end
    total++; if (i4 !== 4'd0) begin bad++; $display("FAIL reset_index got=%0d want=0", i4); end
    total++; if (q4 !== 128'h0) begin bad++; $display("FAIL reset_data got=%h want=0", q4); end
    total++; if (d4 !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", d4); end
    rst = 1'b0;
  endtask

  task automatic test_nk4;
    sel = 0; key = K4;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++; if (obs_busy !== 1'b1) begin bad++; $display("FAIL nk4_busy got=%0b want=1", obs_busy); end
    collect(1'b0, -1, 1'b0, 1'b0, 200);
    total++; if (nacc !== 11) begin bad++; $display("FAIL nk4_count got=%0d want=11", nacc); end
    for (int r = 0; r < 11; r++) begin
      total++;
      if (kd[r] !== EXP4[r] || ki[r] !== 4'(r)) begin
        bad++; $display("FAIL nk4_key%0d got=%0d:%h want=%0d:%h", r, ki[r], kd[r], r, EXP4[r]);
      end
    end
    total++; if (ndone !== 1) begin bad++; $display("FAIL nk4_done_count got=%0d want=1", ndone); end
    total++; if (done_at !== last_at + 1) begin
      bad++; $display("FAIL nk4_done_timing got=%0d want=%0d", done_at, last_at + 1);
    end
    total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL nk4_idle_busy got=%0b want=0", obs_busy); end
  endtask

  task automatic test_nk6;
    sel = 1; key = K6;
    collect(1'b1, -1, 1'b0, 1'b0, 300);
    total++; if (nacc !== 13) begin bad++; $display("FAIL nk6_count got=%0d want=13", nacc); end
    for (int r = 0; r < 13; r++) begin
      total++; if (ki[r] !== 4'(r)) begin bad++; $display("FAIL nk6_index%0d got=%0d want=%0d", r, ki[r], r); end
    end
    total++; if (kd[0] !== 128'h8e73b0f7da0e6452c810f32b809079e5) begin
      bad++; $display("FAIL nk6_key0 got=%h want=8e73b0f7da0e6452c810f32b809079e5", kd[0]);
    end
    total++; if (kd[1] !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5) begin
      bad++; $display("FAIL nk6_key1 got=%h want=62f8ead2522c6b7bfe0c91f72402f5a5", kd[1]);
    end
    total++; if (kd[12] !== 128'he98ba06f448c773c8ecc720401002202) begin
      bad++; $display("FAIL nk6_key12 got=%h want=e98ba06f448c773c8ecc720401002202", kd[12]);
    end
    total++; if (ndone !== 1 || done_at !== last_at + 1) begin
      bad++; $display("FAIL nk6_done got=%0d@%0d want=1@%0d", ndone, done_at, last_at + 1);
    end
  endtask

  task automatic test_nk8;
    sel = 2; key = K8;
    collect(1'b1, -1, 1'b0, 1'b0, 300);
    total++; if (nacc !== 15) begin bad++; $display("FAIL nk8_count got=%0d want=15", nacc); end
    total++; if (kd[0] !== 128'h603deb1015ca71be2b73aef0857d7781) begin
      bad++; $display("FAIL nk8_key0 got=%h want=603deb1015ca71be2b73aef0857d7781", kd[0]);
    end
    total++; if (kd[1] !== 128'h1f352c073b6108d72d9810a30914dff4) begin
      bad++; $display("FAIL nk8_key1 got=%h want=1f352c073b6108d72d9810a30914dff4", kd[1]);
    end
    total++; if (kd[2] !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin
      bad++; $display("FAIL nk8_key2 got=%h want=9ba354118e6925afa51a8b5f2067fcde", kd[2]);
    end
    total++; if (kd[3] !== 128'ha8b09c1a93d194cdbe49846eb75d5b9a) begin
      bad++; $display("FAIL nk8_key3 got=%h want=a8b09c1a93d194cdbe49846eb75d5b9a", kd[3]);
    end
    total++; if (kd[14] !== 128'hfe4890d1e6188d0b046df344706c631e || ki[14] !== 4'd14) begin
      bad++; $display("FAIL nk8_key14 got=%0d:%h want=14:fe4890d1e6188d0b046df344706c631e", ki[14], kd[14]);
    end
    total++; if (ndone !== 1 || done_at !== last_at + 1) begin
      bad++; $display("FAIL nk8_done got=%0d@%0d want=1@%0d", ndone, done_at, last_at + 1);
    end
  endtask

  task automatic test_backpressure;
    sel = 0; key = K4;
    collect(1'b1, -1, 1'b0, 1'b1, 800);
    total++; if (nacc !== 11) begin bad++; $display("FAIL bp_count got=%0d want=11", nacc); end
    for (int r = 0; r < 11; r++) begin
      total++;
      if (kd[r] !== EXP4[r] || ki[r] !== 4'(r)) begin
        bad++; $display("FAIL bp_key%0d got=%0d:%h want=%0d:%h", r, ki[r], kd[r], r, EXP4[r]);
      end
    end
    total++; if (stable_bad !== 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", stable_bad); end
    total++; if (ndone !== 1) begin bad++; $display("FAIL bp_done got=%0d want=1", ndone); end
  endtask

  task automatic test_back_to_back;
    sel = 0; key = K4;
    collect(1'b1, 6, 1'b1, 1'b0, 300);
    total++; if (nacc !== 11) begin bad++; $display("FAIL b2b_first_count got=%0d want=11", nacc); end
    for (int r = 0; r < 11; r++) begin
      total++;
      if (kd[r] !== EXP4[r]) begin bad++; $display("FAIL b2b_first_key%0d got=%h want=%h", r, kd[r], EXP4[r]); end
    end
    collect(1'b0, -1, 1'b0, 1'b0, 300);
    total++; if (nacc !== 11) begin bad++; $display("FAIL b2b_second_count got=%0d want=11", nacc); end
    for (int r = 0; r < 11; r++) begin
      total++;
      if (kd[r] !== EXP4[r] || ki[r] !== 4'(r)) begin
        bad++; $display("FAIL b2b_second_key%0d got=%0d:%h want=%0d:%h", r, ki[r], kd[r], r, EXP4[r]);
      end
    end
  endtask

  task automatic test_reset_midrun;
    bit found = 1'b0;
    sel = 0; key = K4;
    @(negedge clk); start = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); start = 1'b0; rdy = 1'b1;
      if (obs_valid && obs_idx == 4'd3) begin found = 1'b1; break; end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL mid_wait_idx3 got=0 want=1"); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_done !== 1'b0) begin
      bad++; $display("FAIL mid_rst_ctrl got=%0b%0b%0b want=000", obs_valid, obs_busy, obs_done);
    end
    total++; if (obs_idx !== 4'd0 || obs_data !== 128'h0) begin
      bad++; $display("FAIL mid_rst_data got=%0d:%h want=0:0", obs_idx, obs_data);
    end
    @(negedge clk); rst = 1'b0;
    collect(1'b1, -1, 1'b0, 1'b0, 200);
    total++; if (nacc !== 11) begin bad++; $display("FAIL mid_count got=%0d want=11", nacc); end
    for (int r = 0; r < 11; r++) begin
      total++;
      if (kd[r] !== EXP4[r] || ki[r] !== 4'(r)) begin
        bad++; $display("FAIL mid_key%0d got=%0d:%h want=%0d:%h", r, ki[r], kd[r], r, EXP4[r]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_nk4;
    test_nk6;
    test_nk8;
    test_backpressure;
    test_back_to_back;
    test_reset_midrun;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
